// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC peripheral window, APB bridge state type and index-width helpers
package noc_pkg;

    localparam logic [55:0] PERIPH_BASE = 56'h4000_0000;
    localparam logic [55:0] PERIPH_SIZE = 56'h1000_0000;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

    // Width of a slot index; never zero so single-slot builds still get a 1-bit field.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a 32-bit lane index within a NoC data word.
    function automatic int lane_w(input int dw);
        return (dw > 32) ? $clog2(dw / 32) : 1;
    endfunction

endpackage

// File: rtl/noc_apb_decode.sv
// noc_apb_decode: maps a NoC byte address to {valid, slot, lane, slot-relative offset}
module noc_apb_decode
    import noc_pkg::*;
#(
    parameter int                    NUM_SLAVES  = 8,
    parameter int                    ADDR_WIDTH  = 56,
    parameter int                    DATA_WIDTH  = 128,
    parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE = ADDR_WIDTH'(noc_pkg::PERIPH_BASE),
    parameter int                    SLOT_SHIFT  = 24
) (
    input  logic [ADDR_WIDTH-1:0]             i_addr,
    output logic                              o_valid,
    output logic [slot_w(NUM_SLAVES)-1:0]     o_slot,
    output logic [lane_w(DATA_WIDTH)-1:0]     o_lane,
    output logic [SLOT_SHIFT-1:0]             o_offset
);

    localparam int                    SW  = slot_w(NUM_SLAVES);
    localparam int                    LW  = lane_w(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WIN = ADDR_WIDTH'(1) << (SLOT_SHIFT + 4);

    logic [ADDR_WIDTH-1:0] w_off;
    logic [3:0]            w_slot4;

    // Window check uses the offset so a below-base address (which wraps) fails it too.
    always_comb begin
        w_off    = i_addr - PERIPH_BASE;
        w_slot4  = w_off[SLOT_SHIFT+3:SLOT_SHIFT];
        o_valid  = (i_addr >= PERIPH_BASE) && (w_off < WIN) &&
                   ({1'b0, w_slot4} < 5'(NUM_SLAVES)) && (i_addr[1:0] == 2'b00);
        o_slot   = w_slot4[SW-1:0];
        o_lane   = (DATA_WIDTH > 32) ? i_addr[LW+1:2] : '0;
        o_offset = w_off[SLOT_SHIFT-1:0];
    end

endmodule

// File: rtl/noc_apb_bridge.sv
// noc_apb_bridge: single-outstanding NoC peripheral request to APB master with timeout
module noc_apb_bridge
    import noc_pkg::*;
#(
    parameter int                    NUM_SLAVES     = 8,
    parameter int                    ADDR_WIDTH     = 56,
    parameter int                    DATA_WIDTH     = 128,
    parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE    = ADDR_WIDTH'(noc_pkg::PERIPH_BASE),
    parameter int                    SLOT_SHIFT     = 24,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       periph_req_in,
    input  logic                       periph_we_in,
    input  logic [ADDR_WIDTH-1:0]      periph_addr_in,
    input  logic [DATA_WIDTH-1:0]      periph_wdata_in,
    output logic [DATA_WIDTH-1:0]      periph_rdata_out,
    output logic                       periph_ack_out,
    output logic                       periph_error_out,
    output logic [NUM_SLAVES-1:0]      psel_out,
    output logic                       penable_out,
    output logic                       pwrite_out,
    output logic [SLOT_SHIFT-1:0]      paddr_out,
    output logic [31:0]                pwdata_out,
    input  logic [NUM_SLAVES*32-1:0]   prdata_in,
    input  logic [NUM_SLAVES-1:0]      pready_in,
    input  logic [NUM_SLAVES-1:0]      pslverr_in
);

    localparam int SW = slot_w(NUM_SLAVES);
    localparam int LW = lane_w(DATA_WIDTH);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    apb_state_e             r_state;
    logic [SW-1:0]          r_slot;
    logic [LW-1:0]          r_lane;
    logic [CW-1:0]          r_cnt;
    logic                   w_valid;
    logic [SW-1:0]          w_slot;
    logic [LW-1:0]          w_lane;
    logic [SLOT_SHIFT-1:0]  w_offset;
    logic [DATA_WIDTH-1:0]  w_rdata;

    noc_apb_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PERIPH_BASE(PERIPH_BASE),
        .SLOT_SHIFT (SLOT_SHIFT)
    ) u_decode (
        .i_addr  (periph_addr_in),
        .o_valid (w_valid),
        .o_slot  (w_slot),
        .o_lane  (w_lane),
        .o_offset(w_offset)
    );

    // Selected slot's read word placed back into the lane it was addressed in.
    always_comb w_rdata = DATA_WIDTH'(prdata_in[r_slot*32 +: 32]) << (r_lane * 32);

    // Bridge FSM with all APB and NoC response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_slot           <= '0;
            r_lane           <= '0;
            r_cnt            <= '0;
            psel_out         <= '0;
            penable_out      <= 1'b0;
            pwrite_out       <= 1'b0;
            paddr_out        <= '0;
            pwdata_out       <= '0;
            periph_ack_out   <= 1'b0;
            periph_error_out <= 1'b0;
            periph_rdata_out <= '0;
        end else begin
            case (r_state)
                IDLE: if (periph_req_in) begin
                    if (w_valid) begin
                        r_slot     <= w_slot;
                        r_lane     <= w_lane;
                        pwrite_out <= periph_we_in;
                        paddr_out  <= w_offset;
                        pwdata_out <= periph_wdata_in[w_lane*32 +: 32];
                        psel_out   <= NUM_SLAVES'(1) << w_slot;
                        r_state    <= SETUP;
                    end else begin
                        periph_ack_out   <= 1'b1;
                        periph_error_out <= 1'b1;
                        periph_rdata_out <= '0;
                        r_state          <= RESP;
                    end
                end
                SETUP: begin
                    penable_out <= 1'b1;
                    r_state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_in[r_slot]) begin
                        psel_out         <= '0;
                        penable_out      <= 1'b0;
                        r_cnt            <= '0;
                        periph_ack_out   <= 1'b1;
                        periph_error_out <= pslverr_in[r_slot];
                        periph_rdata_out <= pwrite_out ? '0 : w_rdata;
                        r_state          <= RESP;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        psel_out         <= '0;
                        penable_out      <= 1'b0;
                        r_cnt            <= '0;
                        periph_ack_out   <= 1'b1;
                        periph_error_out <= 1'b1;
                        periph_rdata_out <= '0;
                        r_state          <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    periph_ack_out   <= 1'b0;
                    periph_error_out <= 1'b0;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_apb_bridge.sv
// tb_noc_apb_bridge: randomized self-checking bench with an address-rule reference model
module tb_noc_apb_bridge;

    localparam int           T    = 1024;
    localparam logic [55:0]  BASE = 56'h4000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         periph_req_in;
    logic         periph_we_in;
    logic [55:0]  periph_addr_in;
    logic [127:0] periph_wdata_in;
    logic [127:0] periph_rdata_out;
    logic         periph_ack_out;
    logic         periph_error_out;
    logic [7:0]   psel_out;
    logic         penable_out;
    logic         pwrite_out;
    logic [23:0]  paddr_out;
    logic [31:0]  pwdata_out;
    logic [255:0] prdata_in;
    logic [7:0]   pready_in;
    logic [7:0]   pslverr_in;

    int checks = 0;
    int failures = 0;

    int           o_ack_cyc;
    logic [127:0] o_rdata;
    logic         o_err;
    logic [7:0]   o_psel_setup;
    logic [7:0]   o_psel_at_ack;
    logic         o_any_psel;
    logic         o_pwrite;
    logic [23:0]  o_paddr;
    logic [31:0]  o_pwdata;

    noc_apb_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .periph_req_in(periph_req_in), .periph_we_in(periph_we_in),
        .periph_addr_in(periph_addr_in), .periph_wdata_in(periph_wdata_in),
        .periph_rdata_out(periph_rdata_out), .periph_ack_out(periph_ack_out),
        .periph_error_out(periph_error_out), .psel_out(psel_out),
        .penable_out(penable_out), .pwrite_out(pwrite_out),
        .paddr_out(paddr_out), .pwdata_out(pwdata_out),
        .prdata_in(prdata_in), .pready_in(pready_in), .pslverr_in(pslverr_in)
    );

    always #5 clk = ~clk;

    function automatic bit m_valid(input logic [55:0] a);
        return (a >= BASE) && (a < BASE + 56'h1000_0000) &&
               (((a - BASE) / 56'h100_0000) < 8) && (a % 4 == 0);
    endfunction

    function automatic int m_slot(input logic [55:0] a);
        return m_valid(a) ? int'((a - BASE) / 56'h100_0000) : 99;
    endfunction

    function automatic int m_lane(input logic [55:0] a);
        return int'((a % 16) / 4);
    endfunction

    function automatic logic [23:0] m_off(input logic [55:0] a);
        return 24'((a - BASE) % 56'h100_0000);
    endfunction

    // Drives one request and plays the addressed slave: pready after `waits` low ACCESS cycles.
    task automatic do_txn(input logic [55:0] a, input logic we, input logic [127:0] wd,
                          input int waits, input logic [31:0] prd, input logic serr,
                          input logic stray);
        int acc;
        int slot;
        slot = m_slot(a);
        @(negedge clk);
        periph_addr_in  = a;
        periph_we_in    = we;
        periph_wdata_in = wd;
        periph_req_in   = 1'b1;
        for (int i = 0; i < 8; i++) prdata_in[i*32 +: 32] = $urandom;
        if (slot < 8) prdata_in[slot*32 +: 32] = prd;
        pready_in = stray ? ~(8'd1 << slot) : 8'd0;
        pslverr_in = 8'($urandom);
        if (slot < 8) pslverr_in[slot] = serr;
        acc = 0;
        o_ack_cyc = -1;
        o_any_psel = 1'b0;
        for (int c = 1; c <= T + 20; c++) begin
            @(negedge clk);
            if (psel_out != 0) o_any_psel = 1'b1;
            if (c == 1) begin
                o_psel_setup = psel_out;
                o_pwrite     = pwrite_out;
                o_paddr      = paddr_out;
                o_pwdata     = pwdata_out;
            end
            if (periph_ack_out) begin
                o_ack_cyc     = c;
                o_rdata       = periph_rdata_out;
                o_err         = periph_error_out;
                o_psel_at_ack = psel_out;
                break;
            end
            pready_in = stray ? ~(8'd1 << slot) : 8'd0;
            if (slot < 8 && penable_out && psel_out[slot]) begin
                if (acc == waits) pready_in[slot] = 1'b1;
                acc++;
            end
        end
        periph_req_in = 1'b0;
        pready_in     = 8'd0;
        checks++;
        if (o_ack_cyc < 0) begin
            failures++;
            $display("FAIL ack_bound no ack within %0d cycles for addr %h", T + 20, a);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        periph_req_in = 1'b0;
        periph_we_in = 1'b0;
        periph_addr_in = '0;
        periph_wdata_in = '0;
        prdata_in = '0;
        pready_in = '0;
        pslverr_in = '0;
        #3;
        checks++;
        if ({periph_rdata_out, periph_ack_out, periph_error_out, psel_out, penable_out,
             pwrite_out, paddr_out, pwdata_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b err=%b psel=%h pen=%b rdata=%h exp all zero",
                     periph_ack_out, periph_error_out, psel_out, penable_out, periph_rdata_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read;
        do_txn(56'h4200_0004, 1'b0, 128'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        checks++;
        if (o_psel_setup !== 8'h04) begin
            failures++;
            $display("FAIL read_psel got=%h exp=%h", o_psel_setup, 8'h04);
        end
        checks++;
        if (o_ack_cyc != 3) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=3", o_ack_cyc);
        end
        checks++;
        if (o_rdata !== 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL read_data got=%h err=%b exp=%h err=0", o_rdata, o_err,
                     128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000);
        end
    endtask

    task automatic test_write;
        do_txn(56'h4000_000C, 1'b1, {32'h12345678, 96'hA5A5_0000_1111_2222_3333_4444},
               3, 32'hFFFF_FFFF, 1'b0, 1'b0);
        checks++;
        if (o_pwdata !== 32'h12345678 || o_pwrite !== 1'b1 || o_paddr !== 24'h00000C) begin
            failures++;
            $display("FAIL write_apb got pwdata=%h pwrite=%b paddr=%h exp 12345678 1 00000c",
                     o_pwdata, o_pwrite, o_paddr);
        end
        checks++;
        if (o_ack_cyc != 6 || o_rdata !== '0 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL write_resp got cyc=%0d rdata=%h err=%b exp cyc=6 rdata=0 err=0",
                     o_ack_cyc, o_rdata, o_err);
        end
    endtask

    task automatic test_decode_err;
        logic [55:0] addrs [3];
        addrs = '{56'h4900_0000, 56'h3FFF_FFF0, 56'h4000_0002};
        foreach (addrs[i]) begin
            do_txn(addrs[i], 1'b0, 128'h0, 0, 32'h1234, 1'b0, 1'b0);
            checks++;
            if (o_ack_cyc != 1 || o_err !== 1'b1 || o_rdata !== '0 || o_any_psel !== 1'b0) begin
                failures++;
                $display("FAIL decode_err addr=%h got cyc=%0d err=%b rdata=%h psel_seen=%b exp 1 1 0 0",
                         addrs[i], o_ack_cyc, o_err, o_rdata, o_any_psel);
            end
        end
    endtask

    task automatic test_timeout;
        do_txn(56'h4500_0010, 1'b0, 128'h0, 1 << 30, 32'hCAFE, 1'b0, 1'b0);
        checks++;
        if (o_ack_cyc != 2 + T || o_err !== 1'b1 || o_rdata !== '0 || o_psel_at_ack !== 8'h00) begin
            failures++;
            $display("FAIL timeout got cyc=%0d err=%b rdata=%h psel=%h exp cyc=%0d err=1 rdata=0 psel=0",
                     o_ack_cyc, o_err, o_rdata, o_psel_at_ack, 2 + T);
        end
    endtask

    task automatic test_pslverr;
        do_txn(56'h4100_0000, 1'b0, 128'h0, 0, 32'h5555_AAAA, 1'b1, 1'b1);
        checks++;
        if (o_ack_cyc != 3 || o_err !== 1'b1) begin
            failures++;
            $display("FAIL pslverr got cyc=%0d err=%b exp cyc=3 err=1", o_ack_cyc, o_err);
        end
        do_txn(56'h4100_0008, 1'b0, 128'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b1);
        checks++;
        if (o_ack_cyc != 5 || o_err !== 1'b0 || o_rdata !== {32'h0, 32'h0BAD_F00D, 64'h0}) begin
            failures++;
            $display("FAIL stray_pready got cyc=%0d err=%b rdata=%h exp cyc=5 err=0 rdata=%h",
                     o_ack_cyc, o_err, o_rdata, {32'h0, 32'h0BAD_F00D, 64'h0});
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        periph_addr_in = 56'h4300_0000;
        periph_we_in   = 1'b0;
        periph_req_in  = 1'b1;
        pready_in      = 8'd0;
        repeat (4) @(negedge clk);
        checks++;
        if (psel_out !== 8'h08 || penable_out !== 1'b1) begin
            failures++;
            $display("FAIL mid_access got psel=%h pen=%b exp psel=08 pen=1", psel_out, penable_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({periph_rdata_out, periph_ack_out, periph_error_out, psel_out, penable_out,
             pwrite_out, paddr_out, pwdata_out} !== '0) begin
            failures++;
            $display("FAIL async_reset got psel=%h pen=%b paddr=%h ack=%b exp all zero",
                     psel_out, penable_out, paddr_out, periph_ack_out);
        end
        periph_req_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(56'h4300_0024, 1'b0, 128'h0, 0, 32'h3333_7777, 1'b0, 1'b0);
        checks++;
        if (o_ack_cyc != 3 || o_err !== 1'b0 || o_rdata !== {32'h0, 32'h0, 32'h3333_7777, 32'h0}) begin
            failures++;
            $display("FAIL post_reset_read got cyc=%0d err=%b rdata=%h exp cyc=3 err=0",
                     o_ack_cyc, o_err, o_rdata);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic [55:0]  a;
            logic         we, serr, stray, v;
            logic [127:0] wd;
            logic [31:0]  prd;
            int           waits, exp_cyc;
            logic [127:0] exp_rdata;
            case ($urandom_range(0, 5))
                0:       a = BASE + 56'($urandom_range(8, 15)) * 56'h100_0000 + 56'($urandom_range(0, 255) * 4);
                1:       a = BASE - 56'($urandom_range(1, 4096));
                2:       a = BASE + 56'($urandom_range(0, 7)) * 56'h100_0000 + 56'($urandom_range(0, 255) * 4 + 1);
                default: a = BASE + 56'($urandom_range(0, 7)) * 56'h100_0000 + 56'($urandom_range(0, 4194303) * 4);
            endcase
            we = 1'($urandom);
            serr = 1'($urandom);
            stray = 1'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
            prd = $urandom;
            waits = $urandom_range(0, 5);
            v = m_valid(a);
            do_txn(a, we, wd, waits, prd, serr, stray);
            exp_cyc = v ? 3 + waits : 1;
            exp_rdata = (v && !we) ? (128'(prd) << (32 * m_lane(a))) : 128'h0;
            checks++;
            if (o_ack_cyc != exp_cyc || o_err !== (!v || serr) || o_rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rand_resp addr=%h got cyc=%0d err=%b rdata=%h exp cyc=%0d err=%b rdata=%h",
                         a, o_ack_cyc, o_err, o_rdata, exp_cyc, !v || serr, exp_rdata);
            end
            checks++;
            if (v && (o_psel_setup !== (8'd1 << m_slot(a)) || o_paddr !== m_off(a) ||
                      o_pwrite !== we || o_pwdata !== 32'(wd >> (32 * m_lane(a))))) begin
                failures++;
                $display("FAIL rand_apb addr=%h got psel=%h paddr=%h pwrite=%b pwdata=%h exp psel=%h paddr=%h",
                         a, o_psel_setup, o_paddr, o_pwrite, o_pwdata, 8'd1 << m_slot(a), m_off(a));
            end else if (!v && o_any_psel !== 1'b0) begin
                failures++;
                $display("FAIL rand_no_apb addr=%h got psel activity exp none", a);
            end
        end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_decode_err;
        test_timeout;
        test_pslverr;
        test_async_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
